// File: rtl/tmr_voter_monitor.sv
// Registered TMR majority voter with per-replica mismatch monitoring.
// Define TMR_VOTER_MONITOR_DEGRADE_EN to retire faulty replicas (DEGRADED).
module tmr_voter_monitor #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned CntWidth       = 8,
  parameter int unsigned FaultThreshold = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DataWidth-1:0]  data_a_i,
  input  logic [DataWidth-1:0]  data_b_i,
  input  logic [DataWidth-1:0]  data_c_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DataWidth-1:0]  data_o,
  output logic                  error_o,
  output logic                  fatal_o,
  output logic [2:0]            faulty_o,
  output logic [1:0]            state_o,
  output logic [3*CntWidth-1:0] fault_cnt_o,
  input  logic                  clear_i
);

  typedef enum logic [1:0] {
    StNormal   = 2'b00,
    StDegraded = 2'b01,
    StFail     = 2'b10
  } state_e;

  typedef logic [DataWidth-1:0] word_t;
  typedef logic [CntWidth-1:0]  cnt_t;

  localparam cnt_t CntMax = '1;

  word_t [2:0] word;
  word_t       vote;
  logic  [2:0] mis;
  logic        xfer_in;

  state_e      state_q, state_d;
  logic        fatal_q, fatal_d;
  cnt_t  [2:0] cnt_q, cnt_d;
  logic  [2:0] bump;
  word_t       out_d;
  logic        err_d;

  word_t       data_q;
  logic        err_q;
  logic        valid_q;

  assign word = {data_c_i, data_b_i, data_a_i};
  assign vote = (data_a_i & data_b_i)
              | (data_a_i & data_c_i)
              | (data_b_i & data_c_i);

  assign ready_o = !valid_q || ready_i;
  assign xfer_in = valid_i && ready_o;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mis[i] = word[i] != vote;
    end
  end

`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
  localparam logic [7:0] Thresh = 8'(FaultThreshold);

  logic [2:0][7:0] streak_q, streak_d;
  logic [2:0]      faulty_q, faulty_d;
  logic [1:0]      h0, h1;

  // h0/h1: the two surviving replicas, h0 lower index
  always_comb begin
    h0 = 2'd0;
    h1 = 2'd1;
    unique case (1'b1)
      faulty_q[0]: begin
        h0 = 2'd1;
        h1 = 2'd2;
      end
      faulty_q[1]: h1 = 2'd2;
      default: ;
    endcase
  end

  assign faulty_o = faulty_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^FaultThreshold;
  assign faulty_o = 3'b000;
`endif

  always_comb begin
    state_d = state_q;
    fatal_d = fatal_q;
    out_d   = vote;
    err_d   = 1'b0;
    bump    = 3'b000;
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
    streak_d = streak_q;
    faulty_d = faulty_q;
`endif
    unique case (state_q)
      StNormal: begin
        err_d = |mis;
        bump  = mis;
        if (|mis && !$onehot(mis)) begin
          state_d = StFail;
          fatal_d = 1'b1;
        end
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
        for (int i = 0; i < 3; i++) begin
          if (!mis[i]) begin
            streak_d[i] = '0;
          end else if ($onehot(mis)) begin
            streak_d[i] = streak_q[i] + 8'd1;
            if (streak_q[i] == Thresh - 8'd1) begin
              faulty_d[i] = 1'b1;
              state_d     = StDegraded;
            end
          end
        end
`endif
      end
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
      StDegraded: begin
        out_d = word[h0];
        if (word[h0] != word[h1]) begin
          err_d    = 1'b1;
          bump[h0] = 1'b1;
          bump[h1] = 1'b1;
          state_d  = StFail;
          fatal_d  = 1'b1;
        end
      end
`endif
      default: begin
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
        out_d = word[h0];
        for (int i = 0; i < 3; i++) begin
          bump[i] = !faulty_q[i] && (word[i] != word[h0]);
        end
`else
        bump = mis;
`endif
        err_d = |bump;
      end
    endcase
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bump[i] && cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (xfer_in) begin
      valid_q <= 1'b1;
      data_q  <= out_d;
      err_q   <= err_d;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // clear wins over this cycle's monitoring update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StNormal;
      fatal_q <= 1'b0;
      cnt_q   <= '0;
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
      streak_q <= '0;
      faulty_q <= '0;
`endif
    end else if (clear_i) begin
      state_q <= StNormal;
      fatal_q <= 1'b0;
      cnt_q   <= '0;
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
      streak_q <= '0;
      faulty_q <= '0;
`endif
    end else if (xfer_in) begin
      state_q <= state_d;
      fatal_q <= fatal_d;
      cnt_q   <= cnt_d;
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
      streak_q <= streak_d;
      faulty_q <= faulty_d;
`endif
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign error_o     = err_q;
  assign fatal_o     = fatal_q;
  assign state_o     = state_q;
  assign fault_cnt_o = cnt_q;

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Directed + random bench for tmr_voter_monitor with a behavioural model.
// Follows TMR_VOTER_MONITOR_DEGRADE_EN the same way as the design.
module tb_tmr_voter_monitor;

  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int TH   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic          clear_i = 1'b0;
  logic [DW-1:0] a_i     = '0;
  logic [DW-1:0] b_i     = '0;
  logic [DW-1:0] c_i     = '0;

  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          error_o;
  logic          fatal_o;
  logic [2:0]    faulty_o;
  logic [1:0]    state_o;
  logic [3*CW-1:0] fault_cnt_o;

  always #5 clk = ~clk;

  tmr_voter_monitor #(
    .DataWidth(DW),
    .CntWidth(CW),
    .FaultThreshold(TH)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_a_i(a_i),
    .data_b_i(b_i),
    .data_c_i(c_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o(data_o),
    .error_o(error_o),
    .fatal_o(fatal_o),
    .faulty_o(faulty_o),
    .state_o(state_o),
    .fault_cnt_o(fault_cnt_o),
    .clear_i(clear_i)
  );

  int total = 0;
  int bad   = 0;

  // model state: status as plain ints/flags, state 0/1/2
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_err;
  int            m_state;
  bit            m_fatal;
  bit            m_faulty[3];
  int            m_cnt[3];
  int            m_streak[3];

  logic [3*CW-1:0] exp_cnt;
  logic [DW-1:0]   rw[3];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_state = 0;
    m_fatal = 0;
    for (int i = 0; i < 3; i++) begin
      m_faulty[i] = 0;
      m_cnt[i]    = 0;
      m_streak[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    m_valid = 0;
    m_data  = '0;
    m_err   = 0;
    model_clear();
  endfunction

  function automatic void model_step();
    logic [DW-1:0] w[3];
    logic [DW-1:0] v;
    logic [DW-1:0] o;
    bit mis[3];
    int nm;
    bit e;
    int ns;
    bit nf;
    bit nfl[3];
    int nc[3];
    int nst[3];
    int hl[$];
    w[0] = a_i;
    w[1] = b_i;
    w[2] = c_i;
    if (!(valid_i && (!m_valid || ready_i))) begin
      if (ready_i) m_valid = 0;
      if (clear_i) model_clear();
      return;
    end
    for (int b = 0; b < DW; b++) begin
      v[b] = (int'(w[0][b]) + int'(w[1][b]) + int'(w[2][b])) >= 2;
    end
    nm = 0;
    for (int i = 0; i < 3; i++) begin
      mis[i] = (w[i] != v);
      nm += int'(mis[i]);
    end
    ns  = m_state;
    nf  = m_fatal;
    nfl = m_faulty;
    nc  = m_cnt;
    nst = m_streak;
    for (int i = 0; i < 3; i++) if (!m_faulty[i]) hl.push_back(i);
    o = v;
    e = 0;
    if (m_state == 0) begin
      e = (nm > 0);
      for (int i = 0; i < 3; i++) if (mis[i]) nc[i]++;
      if (nm >= 2) begin
        ns = 2;
        nf = 1;
      end
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
      for (int i = 0; i < 3; i++) begin
        if (!mis[i]) nst[i] = 0;
        else if (nm == 1) begin
          nst[i]++;
          if (nst[i] == TH) begin
            nfl[i] = 1;
            ns = 1;
          end
        end
      end
`endif
    end else if (m_state == 1) begin
      o = w[hl[0]];
      if (w[hl[0]] != w[hl[1]]) begin
        e = 1;
        nc[hl[0]]++;
        nc[hl[1]]++;
        ns = 2;
        nf = 1;
      end
    end else begin
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
      o = w[hl[0]];
      for (int i = 0; i < 3; i++) begin
        if (!m_faulty[i] && w[i] != o) begin
          nc[i]++;
          e = 1;
        end
      end
`else
      for (int i = 0; i < 3; i++) begin
        if (mis[i]) begin
          nc[i]++;
          e = 1;
        end
      end
`endif
    end
    for (int i = 0; i < 3; i++) if (nc[i] > CMAX) nc[i] = CMAX;
    m_valid = 1;
    m_data  = o;
    m_err   = e;
    if (clear_i) model_clear();
    else begin
      m_state  = ns;
      m_fatal  = nf;
      m_faulty = nfl;
      m_cnt    = nc;
      m_streak = nst;
    end
  endfunction

  always @(negedge clk) begin
    exp_cnt = {CW'(m_cnt[2]), CW'(m_cnt[1]), CW'(m_cnt[0])};
    check("ready_o", ready_o, !m_valid || ready_i);
    check("valid_o", valid_o, m_valid);
    if (m_valid) begin
      check("data_o", data_o, m_data);
      check("error_o", error_o, m_err);
    end
    check("fatal_o", fatal_o, m_fatal);
    check("faulty_o", faulty_o,
          {m_faulty[2], m_faulty[1], m_faulty[0]});
    check("state_o", state_o, 32'(m_state));
    check("fault_cnt_o", fault_cnt_o, exp_cnt);
  end

  task automatic step(input logic v, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] c,
                      input logic rdy, input logic clr);
    valid_i = v;
    a_i = a;
    b_i = b;
    c_i = c;
    ready_i = rdy;
    clear_i = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a,
                      input logic [DW-1:0] b,
                      input logic [DW-1:0] c);
    step(1'b1, a, b, c, 1'b1, 1'b0);
  endtask

  task automatic idle_clear();
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  int pk;
  int phase;
  int r;
  int k;

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_data", data_o, 0);
    check("rst_cnt", fault_cnt_o, 0);
    check("rst_state", state_o, 0);
    rst_n = 1'b1;

    for (int n = 0; n < 10; n++) begin
      send(8'h5A, 8'h5A, 8'h5A);
      check("clean_data", data_o, 8'h5A);
      check("clean_err", error_o, 0);
    end
    check("clean_cnt", fault_cnt_o, 0);

    send(8'h00, 8'hFF, 8'hFF);
    check("single_data", data_o, 8'hFF);
    check("single_err", error_o, 1);
    check("single_cnt", fault_cnt_o, 6'h01);
    check("single_state", state_o, 0);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, '0, '0, '0, 1'b0, 1'b0);
      check("stall_valid", valid_o, 1);
      check("stall_data", data_o, 8'hFF);
      check("stall_ready", ready_o, 0);
    end

    for (int n = 0; n < 4; n++) send(8'h33, 8'h3C, 8'h33);
`ifdef TMR_VOTER_MONITOR_DEGRADE_EN
    check("retire_mask", faulty_o, 3'b010);
    check("retire_state", state_o, 2'b01);
`else
    check("retire_mask", faulty_o, 3'b000);
    check("retire_state", state_o, 2'b00);
`endif
    send(8'h11, 8'h99, 8'h22);
    check("pair_data", data_o, 8'h11);
    check("pair_fatal", fatal_o, 1);
    check("pair_state", state_o, 2'b10);

    idle_clear();
    check("clr_state", state_o, 0);
    check("clr_cnt", fault_cnt_o, 0);
    check("clr_fatal", fatal_o, 0);
    send(8'h01, 8'h02, 8'h04);
    check("split_data", data_o, 8'h00);
    check("split_err", error_o, 1);
    check("split_fatal", fatal_o, 1);
    check("split_state", state_o, 2'b10);
    check("split_cnt", fault_cnt_o, 6'h15);
    idle_clear();
    check("clr2_state", state_o, 0);
    check("clr2_cnt", fault_cnt_o, 0);
    check("clr2_fatal", fatal_o, 0);

    for (int n = 0; n < 5; n++) begin
      send(8'h5A, 8'h5A, 8'hA5);
      send(8'h5A, 8'h5A, 8'h5A);
    end
    check("sat_cnt2", fault_cnt_o[2*CW +: CW], 3);
    check("sat_mask", faulty_o, 3'b000);

    pk = 0;
    phase = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        pk = $urandom_range(0, 2);
        phase = $urandom_range(0, 1);
      end
      rw[0] = DW'($urandom);
      rw[1] = rw[0];
      rw[2] = rw[0];
      r = $urandom_range(0, 99);
      if (phase == 1) begin
        if (r < 70) rw[pk] ^= DW'($urandom_range(1, 255));
        else if (r < 75) rw[(pk + 1) % 3] ^= DW'($urandom_range(1, 255));
      end else begin
        k = $urandom_range(0, 2);
        if (r < 30) rw[k] ^= DW'($urandom_range(1, 255));
        else if (r < 40) begin
          rw[k] ^= DW'($urandom_range(1, 255));
          rw[(k + 1) % 3] ^= DW'($urandom_range(1, 255));
        end else if (r < 45) begin
          rw[1] = DW'($urandom);
          rw[2] = DW'($urandom);
        end
      end
      step($urandom_range(0, 9) < 8, rw[0], rw[1], rw[2],
           $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    end

    send(8'hC3, 8'hC3, 8'hC3);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    check("held_valid", valid_o, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_data", data_o, 0);
    check("arst_err", error_o, 0);
    check("arst_fatal", fatal_o, 0);
    check("arst_mask", faulty_o, 0);
    check("arst_state", state_o, 0);
    check("arst_cnt", fault_cnt_o, 0);
    check("arst_ready", ready_o, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_i = 1'b1;
    repeat (2) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
